// File: rtl/apb_slave_ws.sv
// apb_slave_ws -- APB slave front-end with variable wait states.
//
// Decodes a word-aligned register window starting at BASE_ADDR, turns each
// valid APB access into a one-cycle read or write request towards a register
// backend and holds the APB transfer (PREADY=0) until the backend acks.
// Out-of-window, below-base or misaligned addresses complete immediately with
// PSLVERR and never reach the backend. A backend that does not ack within
// TIMEOUT wait cycles also completes with PSLVERR (TIMEOUT=0: wait forever).
//
// Optional feature macro: APB_PSTRB_EN
//   defined   : PSTRB port exists and is forwarded to reg_wstrb on writes
//   undefined : no PSTRB port, writes present reg_wstrb = all ones
//   Reads always present reg_wstrb = 0.
//
// Ports
//   CLK, nRST          clock (posedge), synchronous active-low reset
//   PSEL, PENABLE,
//   PWRITE, PADDR,
//   PWDATA, [PSTRB]    APB requester side
//   PRDATA, PREADY,
//   PSLVERR            APB completer side, all registered
//   reg_index          decoded register index, held from request to ack
//   reg_wen, reg_ren   one-cycle write / read request
//   reg_wdata,
//   reg_wstrb          latched write data and byte strobes
//   reg_rdata, reg_ack backend read data and completion (ack may coincide
//                      with the request cycle)
module apb_slave_ws #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_REGS  = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                TIMEOUT   = 15,
    localparam int               IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int               STRB_W    = DATA_W / 8
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
`ifdef APB_PSTRB_EN
    input  logic [STRB_W-1:0] PSTRB,
`endif
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [IDX_W-1:0]  reg_index,
    output logic              reg_wen,
    output logic              reg_ren,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [STRB_W-1:0] reg_wstrb,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_ack
);

    localparam int ALIGN_W = $clog2(STRB_W);
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Value of the wait counter during the last permitted WAIT cycle.
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   prdata_d;
    logic                pready_d, pslverr_d;
    logic [IDX_W-1:0]    index_d;
    logic                wen_d, ren_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [STRB_W-1:0]   wstrb_d;

    logic [STRB_W-1:0]   strb_in;
    logic [ADDR_W-1:0]   offset, word;
    logic                addr_bad;

`ifdef APB_PSTRB_EN
    assign strb_in = PSTRB;
`else
    assign strb_in = '1;
`endif

    // Address decode straight off the bus; only used in the setup cycle.
    assign offset   = PADDR - BASE_ADDR;
    assign word     = offset >> ALIGN_W;
    assign addr_bad = (PADDR < BASE_ADDR)
                   || (word >= ADDR_W'(NUM_REGS))
                   || ((PADDR & ADDR_W'(STRB_W - 1)) != '0);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            PRDATA    <= '0;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
            reg_index <= '0;
            reg_wen   <= 1'b0;
            reg_ren   <= 1'b0;
            reg_wdata <= '0;
            reg_wstrb <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            wr_q      <= wr_d;
            PRDATA    <= prdata_d;
            PREADY    <= pready_d;
            PSLVERR   <= pslverr_d;
            reg_index <= index_d;
            reg_wen   <= wen_d;
            reg_ren   <= ren_d;
            reg_wdata <= wdata_d;
            reg_wstrb <= wstrb_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        wr_d      = wr_q;
        prdata_d  = PRDATA;
        pready_d  = PREADY;
        pslverr_d = PSLVERR;
        index_d   = reg_index;
        wen_d     = 1'b0;           // requests are single-cycle pulses
        ren_d     = 1'b0;
        wdata_d   = reg_wdata;
        wstrb_d   = reg_wstrb;

        case (state)
            S_IDLE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
                if (PSEL && !PENABLE) begin
                    wr_d = PWRITE;
                    if (addr_bad) begin
                        // Complete in the first access cycle, backend untouched.
                        state_d   = S_DONE;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        index_d = IDX_W'(word);
                        wen_d   = PWRITE;
                        ren_d   = !PWRITE;
                        wdata_d = PWDATA;
                        wstrb_d = PWRITE ? strb_in : '0;
                    end
                end
            end

            S_REQ, S_WAIT: begin
                if (!PSEL) begin
                    // Requester walked away: drop the transfer, ignore any ack.
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (reg_ack) begin
                    // Ack is checked before the timeout so a last-cycle ack wins.
                    state_d   = S_DONE;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b0;
                    prdata_d  = wr_q ? '0 : reg_rdata;
                end else if (state == S_REQ) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST))) begin
                    state_d   = S_DONE;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    prdata_d  = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            S_DONE: begin
                // Leave on a completed access phase or an abandoned select.
                if (!PSEL || PENABLE) begin
                    state_d   = S_IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_slave_ws.sv
// Directed bench for apb_slave_ws (BASE_ADDR='h100, NUM_REGS=16, TIMEOUT=15,
// 32-bit bus). A small APB requester task drives one transfer while acting as
// the backend, acking a given number of cycles after the request it sees.
module tb_apb_slave_ws;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0;
    logic [3:0]  PSTRB = 4'hF;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [3:0]  reg_index;
    logic        reg_wen, reg_ren;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic [31:0] reg_rdata = '0;
    logic        reg_ack = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Results of the last xfer() call.
    logic [31:0] r_rdata, r_wdata;
    logic        r_err;
    logic [3:0]  r_idx, r_wstrb;
    int          r_waits, r_wen, r_ren;

    apb_slave_ws #(
        .ADDR_W(32), .DATA_W(32), .NUM_REGS(16),
        .BASE_ADDR(32'h100), .TIMEOUT(15)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_PSTRB_EN
        .PSTRB(PSTRB),
`endif
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .reg_index(reg_index), .reg_wen(reg_wen), .reg_ren(reg_ren),
        .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One APB transfer. ack_dly < 0: backend never acks.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input int ack_dly, input logic [31:0] rd);
        int  rc;
        bit  done;
        rc = 0; done = 0;
        r_wen = 0; r_ren = 0; r_waits = -1; r_err = 1'bx; r_rdata = 'x;
        r_idx = 'x; r_wstrb = 'x; r_wdata = 'x;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        PSTRB = strb; reg_rdata = rd; reg_ack = 1'b0;
        tick();
        PENABLE = 1'b1;
        for (int c = 1; c <= 40 && !done; c++) begin
            if (reg_wen) r_wen++;
            if (reg_ren) r_ren++;
            if (reg_wen || reg_ren) begin
                rc = c; r_idx = reg_index; r_wstrb = reg_wstrb; r_wdata = reg_wdata;
            end
            if (PREADY) begin
                r_waits = c - 1; r_rdata = PRDATA; r_err = PSLVERR;
                reg_ack = 1'b0; done = 1;
            end else begin
                reg_ack = (rc > 0 && ack_dly >= 0 && c == rc + ack_dly);
            end
            tick();
        end
        PSEL = 1'b0; PENABLE = 1'b0; reg_ack = 1'b0;
        chk("xfer_completed", 32'(done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick(); tick();
        chk("rst_pready", PREADY, 0);   chk("rst_pslverr", PSLVERR, 0);
        chk("rst_prdata", PRDATA, 0);   chk("rst_wen", reg_wen, 0);
        chk("rst_ren", reg_ren, 0);     chk("rst_index", reg_index, 0);
        chk("rst_wdata", reg_wdata, 0); chk("rst_wstrb", reg_wstrb, 0);
        nRST = 1'b1;
        tick();

        // Write BASE+8, same-cycle ack: 1 wait state
        xfer(1'b1, 32'h108, 32'hDEADBEEF, 4'hF, 0, 32'h0);
        chk("wr_index", r_idx, 2);      chk("wr_wen", r_wen, 1);
        chk("wr_ren", r_ren, 0);        chk("wr_wdata", r_wdata, 32'hDEADBEEF);
        chk("wr_wstrb", r_wstrb, 4'hF); chk("wr_waits", r_waits, 1);
        chk("wr_err", r_err, 0);        chk("wr_prdata", r_rdata, 0);
        chk("wr_after_pready", PREADY, 0);
        tick();

        // Read BASE+4, ack 3 cycles after request: 4 wait states
        xfer(1'b0, 32'h104, 32'h0, 4'hF, 3, 32'h1234);
        chk("rd_index", r_idx, 1);      chk("rd_ren", r_ren, 1);
        chk("rd_wen", r_wen, 0);        chk("rd_wstrb", r_wstrb, 0);
        chk("rd_prdata", r_rdata, 32'h1234);
        chk("rd_waits", r_waits, 4);    chk("rd_err", r_err, 0);
        chk("rd_after_pready", PREADY, 0);
        chk("rd_after_prdata", PRDATA, 0);
        tick();

        // Bad addresses: past window, misaligned, below base, misaligned write
        xfer(1'b0, 32'h140, 32'h0, 4'hF, 0, 32'h9);
        chk("oob_err", r_err, 1); chk("oob_waits", r_waits, 0);
        chk("oob_req", 32'(r_wen + r_ren), 0);
        xfer(1'b0, 32'h102, 32'h0, 4'hF, 0, 32'h9);
        chk("mis_err", r_err, 1); chk("mis_waits", r_waits, 0);
        chk("mis_req", 32'(r_wen + r_ren), 0);
        xfer(1'b0, 32'h0FC, 32'h0, 4'hF, 0, 32'h9);
        chk("below_err", r_err, 1); chk("below_req", 32'(r_wen + r_ren), 0);
        xfer(1'b1, 32'h101, 32'h5, 4'hF, 0, 32'h0);
        chk("miswr_err", r_err, 1); chk("miswr_req", 32'(r_wen + r_ren), 0);
        chk("miswr_prdata", r_rdata, 0);
        tick();

        // Timeout: no ack -> error after 15 WAIT cycles; ack on 15th WAIT wins
        xfer(1'b0, 32'h110, 32'h0, 4'hF, -1, 32'hAAAA);
        chk("to_err", r_err, 1); chk("to_waits", r_waits, 16);
        chk("to_prdata", r_rdata, 0);
        xfer(1'b0, 32'h110, 32'h0, 4'hF, 15, 32'hAAAA);
        chk("ack15_err", r_err, 0); chk("ack15_waits", r_waits, 16);
        chk("ack15_prdata", r_rdata, 32'hAAAA);
        xfer(1'b0, 32'h110, 32'h0, 4'hF, 16, 32'hAAAA);
        chk("ack16_err", r_err, 1); chk("ack16_prdata", r_rdata, 0);
        tick();

        // Byte strobes
        xfer(1'b1, 32'h10C, 32'h11223344, 4'b0101, 0, 32'h0);
`ifdef APB_PSTRB_EN
        chk("strb_wstrb", r_wstrb, 4'b0101);
`else
        chk("strb_wstrb", r_wstrb, 4'b1111);
`endif
        tick();

        // Back-to-back on the last register
        xfer(1'b1, 32'h13C, 32'hCAFE0001, 4'hF, 1, 32'h0);
        chk("b2b_wr_idx", r_idx, 15); chk("b2b_wr_waits", r_waits, 2);
        xfer(1'b0, 32'h13C, 32'h0, 4'hF, 0, 32'h77);
        chk("b2b_rd_idx", r_idx, 15); chk("b2b_rd_waits", r_waits, 1);
        chk("b2b_rd_prdata", r_rdata, 32'h77);
        tick();

        // PSEL dropped mid-WAIT: transfer abandoned, later ack ignored
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h108;
        tick(); PENABLE = 1'b1; tick(); tick();
        PSEL = 1'b0; PENABLE = 1'b0; tick();
        chk("drop_pready", PREADY, 0);
        reg_ack = 1'b1; reg_rdata = 32'h55; tick(); reg_ack = 1'b0;
        chk("drop_ack_pready", PREADY, 0); chk("drop_ack_prdata", PRDATA, 0);
        tick();
        chk("drop_late_pready", PREADY, 0);

        // Reset held two cycles mid-WAIT, then a late ack
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h104;
        tick(); PENABLE = 1'b1; tick(); tick(); tick();
        chk("pre_rst_index", reg_index, 1);
        nRST = 1'b0; tick(); tick();
        chk("mrst_pready", PREADY, 0);   chk("mrst_pslverr", PSLVERR, 0);
        chk("mrst_prdata", PRDATA, 0);   chk("mrst_ren", reg_ren, 0);
        chk("mrst_index", reg_index, 0); chk("mrst_wstrb", reg_wstrb, 0);
        nRST = 1'b1; reg_ack = 1'b1; reg_rdata = 32'h99; tick(); reg_ack = 1'b0;
        tick();
        chk("mrst_late_pready", PREADY, 0); chk("mrst_late_prdata", PRDATA, 0);
        PSEL = 1'b0; PENABLE = 1'b0; tick();

        // Slave is idle again and takes a fresh transfer
        xfer(1'b0, 32'h120, 32'h0, 4'hF, 2, 32'hBEEF);
        chk("post_idx", r_idx, 8); chk("post_waits", r_waits, 3);
        chk("post_prdata", r_rdata, 32'hBEEF); chk("post_err", r_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
